// File: rtl/gpu_raster_pkg.sv
// Shared types and constants for the triangle setup path: vertex type,
// dispatcher state encoding and the split-point divider latency.
package gpu_raster_pkg;

    localparam int COORD_W    = 10;
    localparam int DIV_CYCLES = 2 * COORD_W + 1;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } vertex_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SORT,
        ST_DIV,
        ST_BF_GO,
        ST_BF_LO,
        ST_BF_HI,
        ST_TF_GO,
        ST_TF_LO,
        ST_TF_HI,
        ST_FIN
    } state_t;

    // Of an equal-y pair, the smaller x is the left vertex; on a tie the first one wins.
    function automatic vertex_t pick_left(vertex_t first, vertex_t second);
        return (second.x < first.x) ? second : first;
    endfunction

    function automatic vertex_t pick_right(vertex_t first, vertex_t second);
        return (second.x < first.x) ? first : second;
    endfunction

endpackage

// File: rtl/tri_split_div.sv
// Sequential signed-by-unsigned restoring divider for the split-point x offset.
// One quotient bit per cycle; done is high during the final step, quotient valid with it.
module tri_split_div
    import gpu_raster_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DIV_CYCLES-1:0] num,
    input  logic [COORD_W-1:0]           den,
    output logic                         done,
    output logic signed [DIV_CYCLES-1:0] quot
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic                  run;
    logic [CNT_W-1:0]      cnt;
    logic                  neg;
    logic [DIV_CYCLES-1:0] quo, quo_nxt;
    logic [COORD_W-1:0]    rem, rem_nxt, den_q, diff;
    logic [COORD_W:0]      rem_sh;
    logic                  fits;

    always_comb begin
        rem_sh  = {rem, quo[DIV_CYCLES-1]};
        fits    = (rem_sh >= {1'b0, den_q});
        // When the trial subtraction fits, the result is below den, so the low bits suffice.
        diff    = rem_sh[COORD_W-1:0] - den_q;
        rem_nxt = fits ? diff : rem_sh[COORD_W-1:0];
        quo_nxt = {quo[DIV_CYCLES-2:0], fits};
    end

    assign done = run && (cnt == CNT_W'(DIV_CYCLES - 1));
    assign quot = neg ? -$signed(quo_nxt) : $signed(quo_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            quo   <= num[DIV_CYCLES-1] ? $unsigned(-num) : $unsigned(num);
            rem   <= '0;
            den_q <= den;
            neg   <= num[DIV_CYCLES-1];
        end else if (run) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
        end
    end

endmodule

// File: rtl/triangle_dispatcher.sv
// Splits an arbitrary triangle at its middle vertex and sequences the
// bottom-flat then top-flat rasterizer units over their start/done handshakes.
module triangle_dispatcher
    import gpu_raster_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] v0_x,
    input  logic [COORD_W-1:0] v0_y,
    input  logic [COORD_W-1:0] v1_x,
    input  logic [COORD_W-1:0] v1_y,
    input  logic [COORD_W-1:0] v2_x,
    input  logic [COORD_W-1:0] v2_y,
    output logic               bf_start,
    output logic [COORD_W-1:0] bf_top_x,
    output logic [COORD_W-1:0] bf_top_y,
    output logic [COORD_W-1:0] bf_bot_l_x,
    output logic [COORD_W-1:0] bf_bot_l_y,
    output logic [COORD_W-1:0] bf_bot_r_x,
    output logic [COORD_W-1:0] bf_bot_r_y,
    input  logic               bf_done,
    output logic               tf_start,
    output logic [COORD_W-1:0] tf_bot_x,
    output logic [COORD_W-1:0] tf_bot_y,
    output logic [COORD_W-1:0] tf_top_l_x,
    output logic [COORD_W-1:0] tf_top_l_y,
    output logic [COORD_W-1:0] tf_top_r_x,
    output logic [COORD_W-1:0] tf_top_r_y,
    input  logic               tf_done,
    output logic               busy,
    output logic               tri_done,
    output logic               degen
);

    state_t  state, state_nxt;
    vertex_t vin0, vin1, vin2;
    vertex_t va, vb, vc, vd, tmp;
    vertex_t bf_top, bf_l, bf_r, tf_bot, tf_l, tf_r;
    logic    degen_q, tf_needed;
    logic    flat_all, flat_bot, flat_top;
    logic    div_start, div_done;
    logic signed [DIV_CYCLES-1:0] div_num, div_quot;
    logic [COORD_W-1:0]           div_den, dy;
    logic signed [COORD_W:0]      dx;

    // Stable three-element sort by y: only strictly-smaller y moves forward.
    always_comb begin
        va  = vin0;
        vb  = vin1;
        vc  = vin2;
        tmp = vin0;
        if (vb.y < va.y) begin tmp = va; va = vb; vb = tmp; end
        if (vc.y < vb.y) begin tmp = vb; vb = vc; vc = tmp; end
        if (vb.y < va.y) begin tmp = va; va = vb; vb = tmp; end
    end

    assign flat_all = (va.y == vc.y);
    assign flat_bot = (vb.y == vc.y);
    assign flat_top = (va.y == vb.y);

    assign dy      = vb.y - va.y;
    assign dx      = $signed({1'b0, vc.x}) - $signed({1'b0, va.x});
    assign div_num = DIV_CYCLES'(dx) * DIV_CYCLES'($signed({1'b0, dy}));
    assign div_den = vc.y - va.y;

    // xD is guaranteed in range, so modular addition of the low bits is exact.
    assign vd.x = COORD_W'(va.x + div_quot);
    assign vd.y = vb.y;

    tri_split_div u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .done  (div_done),
        .quot  (div_quot)
    );

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            ST_IDLE:  if (tri_valid) state_nxt = ST_SORT;
            ST_SORT: begin
                if (flat_all)      state_nxt = ST_FIN;
                else if (flat_bot) state_nxt = ST_BF_GO;
                else if (flat_top) state_nxt = ST_TF_GO;
                else begin
                    state_nxt = ST_DIV;
                    div_start = 1'b1;
                end
            end
            ST_DIV:   if (div_done) state_nxt = ST_BF_GO;
            ST_BF_GO: state_nxt = ST_BF_LO;
            ST_BF_LO: if (!bf_done) state_nxt = ST_BF_HI;
            ST_BF_HI: if (bf_done) state_nxt = tf_needed ? ST_TF_GO : ST_FIN;
            ST_TF_GO: state_nxt = ST_TF_LO;
            ST_TF_LO: if (!tf_done) state_nxt = ST_TF_HI;
            ST_TF_HI: if (tf_done) state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tri_ready && tri_valid) begin
            vin0 <= {v0_x, v0_y};
            vin1 <= {v1_x, v1_y};
            vin2 <= {v2_x, v2_y};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            degen_q   <= 1'b0;
            tf_needed <= 1'b0;
            bf_top    <= '0;
            bf_l      <= '0;
            bf_r      <= '0;
            tf_bot    <= '0;
            tf_l      <= '0;
            tf_r      <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_SORT) begin
                degen_q   <= flat_all;
                tf_needed <= !flat_bot;
                if (flat_bot && !flat_all) begin
                    bf_top <= va;
                    bf_l   <= pick_left(vb, vc);
                    bf_r   <= pick_right(vb, vc);
                end
                if (flat_top && !flat_all) begin
                    tf_bot <= vc;
                    tf_l   <= pick_left(va, vb);
                    tf_r   <= pick_right(va, vb);
                end
            end
            // General case: both halves share the edge B-D.
            if (state == ST_DIV && div_done) begin
                bf_top <= va;
                bf_l   <= pick_left(vb, vd);
                bf_r   <= pick_right(vb, vd);
                tf_bot <= vc;
                tf_l   <= pick_left(vb, vd);
                tf_r   <= pick_right(vb, vd);
            end
        end
    end

    assign tri_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign bf_start  = (state == ST_BF_GO);
    assign tf_start  = (state == ST_TF_GO);
    assign tri_done  = (state == ST_FIN);
    assign degen     = (state == ST_FIN) && degen_q;

    assign bf_top_x   = bf_top.x;
    assign bf_top_y   = bf_top.y;
    assign bf_bot_l_x = bf_l.x;
    assign bf_bot_l_y = bf_l.y;
    assign bf_bot_r_x = bf_r.x;
    assign bf_bot_r_y = bf_r.y;
    assign tf_bot_x   = tf_bot.x;
    assign tf_bot_y   = tf_bot.y;
    assign tf_top_l_x = tf_l.x;
    assign tf_top_l_y = tf_l.y;
    assign tf_top_r_x = tf_r.x;
    assign tf_top_r_y = tf_r.y;

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Directed and randomized bench for triangle_dispatcher with an event scoreboard
// and behavioural models of the two flat-triangle rasterizer units.
module tb_triangle_dispatcher;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst, tri_valid, tri_ready;
    logic [W-1:0] v0_x, v0_y, v1_x, v1_y, v2_x, v2_y;
    logic         bf_start, bf_done, tf_start, tf_done;
    logic [W-1:0] bf_top_x, bf_top_y, bf_bot_l_x, bf_bot_l_y, bf_bot_r_x, bf_bot_r_y;
    logic [W-1:0] tf_bot_x, tf_bot_y, tf_top_l_x, tf_top_l_y, tf_top_r_x, tf_top_r_y;
    logic         busy, tri_done, degen;

    int errors = 0;
    int checks = 0;
    bit bf_auto = 1'b1;
    bit tf_auto = 1'b1;

    typedef struct {
        int         kind;   // 0 = bf_start, 1 = tf_start, 2 = tri_done
        logic [59:0] co;
        logic        dg;
    } ev_t;
    ev_t sb[$];

    triangle_dispatcher dut (
        .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
        .bf_start(bf_start), .bf_top_x(bf_top_x), .bf_top_y(bf_top_y),
        .bf_bot_l_x(bf_bot_l_x), .bf_bot_l_y(bf_bot_l_y),
        .bf_bot_r_x(bf_bot_r_x), .bf_bot_r_y(bf_bot_r_y), .bf_done(bf_done),
        .tf_start(tf_start), .tf_bot_x(tf_bot_x), .tf_bot_y(tf_bot_y),
        .tf_top_l_x(tf_top_l_x), .tf_top_l_y(tf_top_l_y),
        .tf_top_r_x(tf_top_r_x), .tf_top_r_y(tf_top_r_y), .tf_done(tf_done),
        .busy(busy), .tri_done(tri_done), .degen(degen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] lr_pair(int fx, int fy, int sx, int sy);
        if (sx < fx) return {10'(sx), 10'(sy), 10'(fx), 10'(fy)};
        return {10'(fx), 10'(fy), 10'(sx), 10'(sy)};
    endfunction

    function automatic void push_ev(int kind, logic [59:0] co, logic dg);
        ev_t e;
        e.kind = kind;
        e.co   = co;
        e.dg   = dg;
        sb.push_back(e);
    endfunction

    // Reference model: A = earliest min-y vertex, C = latest max-y vertex, B = the other.
    function automatic void model_tri(int x0, int y0, int x1, int y1, int x2, int y2);
        int xs[3], ys[3];
        int ia, ic, ib, xd;
        xs[0] = x0; xs[1] = x1; xs[2] = x2;
        ys[0] = y0; ys[1] = y1; ys[2] = y2;
        ia = 0;
        for (int i = 1; i < 3; i++) if (ys[i] < ys[ia]) ia = i;
        ic = 2;
        for (int i = 1; i >= 0; i--) if (ys[i] > ys[ic]) ic = i;
        ib = 3 - ia - ic;
        if (ys[ia] == ys[ic]) begin
            push_ev(2, 60'd0, 1'b1);
            return;
        end
        if (ys[ib] == ys[ic]) begin
            push_ev(0, {10'(xs[ia]), 10'(ys[ia]), lr_pair(xs[ib], ys[ib], xs[ic], ys[ic])}, 1'b0);
        end else if (ys[ia] == ys[ib]) begin
            push_ev(1, {10'(xs[ic]), 10'(ys[ic]), lr_pair(xs[ia], ys[ia], xs[ib], ys[ib])}, 1'b0);
        end else begin
            xd = xs[ia] + ((ys[ib] - ys[ia]) * (xs[ic] - xs[ia])) / (ys[ic] - ys[ia]);
            push_ev(0, {10'(xs[ia]), 10'(ys[ia]), lr_pair(xs[ib], ys[ib], xd, ys[ib])}, 1'b0);
            push_ev(1, {10'(xs[ic]), 10'(ys[ic]), lr_pair(xs[ib], ys[ib], xd, ys[ib])}, 1'b0);
        end
        push_ev(2, 60'd0, 1'b0);
    endfunction

    task automatic mon(input int kind, input logic [59:0] co, input logic dg);
        ev_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", 64'(kind), 64'd99);
        end else begin
            e = sb.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            if (kind < 2) check(kind == 0 ? "bf_coords" : "tf_coords", 64'(co), 64'(e.co));
            else          check("degen_flag", 64'(dg), 64'(e.dg));
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            if (bf_start === 1'b1)
                mon(0, {bf_top_x, bf_top_y, bf_bot_l_x, bf_bot_l_y, bf_bot_r_x, bf_bot_r_y}, 1'b0);
            if (tf_start === 1'b1)
                mon(1, {tf_bot_x, tf_bot_y, tf_top_l_x, tf_top_l_y, tf_top_r_x, tf_top_r_y}, 1'b0);
            if (tri_done === 1'b1)
                mon(2, 60'd0, degen);
        end
    end

    // Rasterizer unit models: keep done high briefly after start, then low, then high again.
    initial forever begin
        @(negedge clk);
        if (bf_auto && bf_start === 1'b1) begin
            repeat (2) @(negedge clk);
            bf_done = 1'b0;
            repeat (3) @(negedge clk);
            bf_done = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (tf_auto && tf_start === 1'b1) begin
            repeat (1) @(negedge clk);
            tf_done = 1'b0;
            repeat (4) @(negedge clk);
            tf_done = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
        @(negedge clk);
        v0_x = W'(x0); v0_y = W'(y0);
        v1_x = W'(x1); v1_y = W'(y1);
        v2_x = W'(x2); v2_y = W'(y2);
        tri_valid = 1'b1;
        @(negedge clk);
        tri_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (tri_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", 64'(n < 300), 64'd1);
        @(negedge clk);
    endtask

    task automatic run_tri(input int x0, input int y0, input int x1, input int y1, input int x2, input int y2);
        model_tri(x0, y0, x1, y1, x2, y2);
        send(x0, y0, x1, y1, x2, y2);
        wait_done();
    endtask

    task automatic wait_bf_start();
        int n = 0;
        while (bf_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bf_start_within_budget", 64'(n < 100), 64'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 64'(tri_ready), 64'd1);
        check({tag, "_pulses"}, 64'({busy, bf_start, tf_start, tri_done, degen}), 64'd0);
        check({tag, "_coords"}, 64'(|{bf_top_x, bf_top_y, bf_bot_l_x, bf_bot_l_y, bf_bot_r_x,
                                      bf_bot_r_y, tf_bot_x, tf_bot_y, tf_top_l_x, tf_top_l_y,
                                      tf_top_r_x, tf_top_r_y}), 64'd0);
    endtask

    initial begin
        rst = 1'b1; tri_valid = 1'b0; bf_done = 1'b1; tf_done = 1'b1;
        v0_x = '0; v0_y = '0; v1_x = '0; v1_y = '0; v2_x = '0; v2_y = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // General split: A=(10,0) B=(40,10) C=(0,20), xD = 5
        run_tri(10, 0, 0, 20, 40, 10);
        check("t1_bf_l_x", 64'(bf_bot_l_x), 64'd5);
        check("t1_tf_l_x", 64'(tf_top_l_x), 64'd5);
        check("t1_tf_bot_y", 64'(tf_bot_y), 64'd20);

        // Bottom-flat only
        run_tri(5, 0, 9, 7, 1, 7);
        check("t2_bf_l", 64'({bf_bot_l_x, bf_bot_l_y}), 64'({10'd1, 10'd7}));

        // Top-flat only
        run_tri(0, 5, 8, 5, 4, 9);
        check("tf_only_r_x", 64'(tf_top_r_x), 64'd8);

        // Degenerate: pulse on the second cycle after acceptance, idle on the third
        model_tri(3, 4, 8, 4, 1, 4);
        send(3, 4, 8, 4, 1, 4);
        @(negedge clk);
        check("t3_done_degen", 64'({tri_done, degen}), 64'd3);
        @(negedge clk);
        check("t3_idle", 64'({tri_ready, busy}), 64'd2);

        // Truncation toward zero in both directions
        run_tri(0, 0, 500, 1, 1023, 3);
        check("t6_xd_pos", 64'(bf_bot_l_x), 64'd341);
        run_tri(1023, 0, 500, 1, 0, 3);
        check("t6_xd_neg", 64'(bf_bot_r_x), 64'd682);

        // Handshake: done already high at start must not count as completion
        bf_auto = 1'b0;
        model_tri(10, 0, 0, 20, 40, 10);
        send(10, 0, 0, 20, 40, 10);
        wait_bf_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_no_early_tf", 64'({tf_start, tri_done}), 64'd0);
        end
        bf_done = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_tf_wait_low", 64'(tf_start), 64'd0);
        bf_done = 1'b1;
        @(negedge clk);
        check("t4_tf_start", 64'(tf_start), 64'd1);
        wait_done();
        bf_auto = 1'b1;

        // Reset during DIV
        send(10, 0, 0, 20, 40, 10);
        repeat (4) @(negedge clk);
        check("t5_in_div", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("t5_rst_div");
        rst = 1'b0;
        run_tri(0, 0, 500, 1, 1023, 3);

        // Reset while waiting in BF_HI
        bf_auto = 1'b0;
        model_tri(5, 0, 9, 7, 1, 7);
        send(5, 0, 9, 7, 1, 7);
        wait_bf_start();
        bf_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("t5_rst_bfhi");
        rst = 1'b0;
        bf_done = 1'b1;
        check("t5_pending_done", 64'(sb.size()), 64'd1);
        sb.delete();
        bf_auto = 1'b1;
        run_tri(10, 0, 0, 20, 40, 10);

        // Random triangles with small y range so flat and degenerate cases occur
        for (int i = 0; i < 10; i++) begin
            run_tri($urandom_range(0, 1023), $urandom_range(0, 12),
                    $urandom_range(0, 1023), $urandom_range(0, 12),
                    $urandom_range(0, 1023), $urandom_range(0, 12));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
